// File: rtl/uart_ctrl_pkg.sv
// uart_ctrl_pkg: shared widths, arbiter state encoding and default timing constants
package uart_ctrl_pkg;
  localparam int BYTE_W = 8;
  localparam int DEF_GAP_CYCLES = 100;
  localparam int DEF_TIMEOUT_CYCLES = 1000;
  typedef enum logic [1:0] {IDLE, LOAD, GAP, WAIT_TX} arb_state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational rotating-priority picker, first set request at or above ptr wins
module rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] winner,
  output logic         any_req
);
  // scan from the farthest offset down so the closest set bit to ptr is written last
  always_comb begin
    winner = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % N]) winner = W'((int'(ptr) + k) % N);
  end
  assign any_req = |req;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin packet arbiter onto one UART byte port; UART_TX_ARB_TIMEOUT_EN adds a stall timeout
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
`ifdef UART_TX_ARB_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
`endif
  parameter int NUM_REQ = 4,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [BYTE_W*NUM_REQ-1:0]  req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       txBusy,
  output logic [BYTE_W-1:0]          odata,
  output logic                       oe,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
`ifdef UART_TX_ARB_TIMEOUT_EN
  ,
  output logic                       timeout_flag
`endif
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(GAP_CYCLES + 1);
  arb_state_t state;
  logic [IW-1:0] rr_ptr, winner, rr_nxt;
  logic [CW-1:0] gap_cnt;
  logic any_req, last_q;
`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] st_cnt;
`endif
  rr_pick #(.N(NUM_REQ), .W(IW)) u_pick (
    .req(req_valid),
    .ptr(rr_ptr),
    .winner(winner),
    .any_req(any_req)
  );
  assign rr_nxt = (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + IW'(1);
  assign req_ready = (state == LOAD) ? (req_valid & (NUM_REQ'(1) << grant_id)) : '0;
  assign busy = state != IDLE;
  // packet FSM: grant, byte load, inter-byte gap, wait for transmitter idle
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      odata <= '0;
      oe <= 1'b0;
      grant_id <= '0;
      rr_ptr <= '0;
      last_q <= 1'b0;
      gap_cnt <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      st_cnt <= '0;
      timeout_flag <= 1'b0;
`endif
    end else begin
      oe <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      if (state != LOAD) st_cnt <= '0;
`endif
      case (state)
        IDLE: if (any_req) begin
          grant_id <= winner;
          state <= LOAD;
        end
        LOAD: if (req_valid[grant_id]) begin
          odata <= req_data[BYTE_W*int'(grant_id) +: BYTE_W];
          oe <= 1'b1;
          last_q <= req_last[grant_id];
          gap_cnt <= '0;
          state <= GAP;
`ifdef UART_TX_ARB_TIMEOUT_EN
          st_cnt <= '0;
        end else if (st_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          rr_ptr <= rr_nxt;
          timeout_flag <= 1'b1;
          state <= IDLE;
        end else begin
          st_cnt <= st_cnt + TW'(1);
`endif
        end
        GAP: if (gap_cnt == CW'(GAP_CYCLES - 1)) state <= WAIT_TX;
             else gap_cnt <= gap_cnt + CW'(1);
        WAIT_TX: if (!txBusy) begin
          if (last_q) begin
            rr_ptr <= rr_nxt;
            state <= IDLE;
          end else state <= LOAD;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
